// File: rtl/demux_1_2.sv
// rtl/demux_1_2.sv - registered 1-to-2 stream demultiplexer with per-port holding registers
//
// Steers the input stream d to port A (sreg=0) or port B (sreg=1). Each port
// has a one-entry holding register with a valid/ready handshake. A stalled port
// therefore only blocks words routed to itself.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   d        input data, meaningful while d_valid=1
//   d_valid  input data valid
//   d_ready  input accepted this cycle (combinational from sreg and the
//            selected port's valid/ready, never from d_valid)
//   sreg     route select sampled with d: 0 -> A, 1 -> B
//   a        port A data (registered)
//   a_valid  port A holds a word
//   a_ready  port A consumer accepts
//   b        port B data (registered)
//   b_valid  port B holds a word
//   b_ready  port B consumer accepts

module demux_1_2 #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] d,
    input  logic             d_valid,
    output logic             d_ready,
    input  logic             sreg,
    output logic [width-1:0] a,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [width-1:0] b,
    output logic             b_valid,
    input  logic             b_ready
);

    logic [width-1:0] a_q, a_d;
    logic [width-1:0] b_q, b_d;
    logic             a_valid_q, a_valid_d;
    logic             b_valid_q, b_valid_d;
    logic             in_xfer;

    // A port can take a word when it is empty or is being drained this cycle.
    // That second case lets a full port pass data through at full rate.
    assign d_ready = sreg ? (!b_valid_q || b_ready) : (!a_valid_q || a_ready);
    assign in_xfer = d_valid && d_ready;

    always_comb begin
        a_d       = a_q;
        a_valid_d = a_valid_q;
        b_d       = b_q;
        b_valid_d = b_valid_q;

        // A load wins over a drain. The word being read leaves and the new
        // word takes its place in the same edge.
        if (in_xfer && !sreg) begin
            a_d       = d;
            a_valid_d = 1'b1;
        end else if (a_valid_q && a_ready) begin
            a_valid_d = 1'b0;
        end

        if (in_xfer && sreg) begin
            b_d       = d;
            b_valid_d = 1'b1;
        end else if (b_valid_q && b_ready) begin
            b_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q       <= '0;
            b_q       <= '0;
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            a_valid_q <= a_valid_d;
            b_valid_q <= b_valid_d;
        end
    end

    assign a       = a_q;
    assign b       = b_q;
    assign a_valid = a_valid_q;
    assign b_valid = b_valid_q;

endmodule

// File: tb/tb_demux_1_2.sv
// tb/tb_demux_1_2.sv - directed and randomized self-checking bench for demux_1_2

module tb_demux_1_2;

    logic       clk;
    logic       reset;
    logic [7:0] d;
    logic       d_valid;
    logic       d_ready;
    logic       sreg;
    logic [7:0] a;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] b;
    logic       b_valid;
    logic       b_ready;

    int n_assert;
    int n_fail;
    int cnt55;

    // reference state for the randomized phase
    logic [7:0] m_a, m_b;
    logic       m_av, m_bv;
    logic       m_rdy, m_xfer;

    demux_1_2 #(.width(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .d       (d),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .sreg    (sreg),
        .a       (a),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .b       (b),
        .b_valid (b_valid),
        .b_ready (b_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // counts how many times 8'h55 is consumed from port A
    always @(posedge clk) begin
        if (reset && a_valid && a_ready && a == 8'h55) cnt55++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cnt55    = 0;
        reset    = 1'b0;
        d        = 8'h00;
        d_valid  = 1'b0;
        sreg     = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;

        // reset held with random inputs toggling
        for (int i = 0; i < 4; i++) begin
            d       = 8'($urandom_range(0, 255));
            d_valid = 1'($urandom_range(0, 1));
            sreg    = 1'($urandom_range(0, 1));
            a_ready = 1'($urandom_range(0, 1));
            b_ready = 1'($urandom_range(0, 1));
            step();
        end
        check("rst_a_valid", a_valid, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        check("rst_d_ready", d_ready, 1);

        d_valid = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        reset   = 1'b1;
        step();

        // basic route to A
        d = 8'h3C; sreg = 1'b0; d_valid = 1'b1; a_ready = 1'b1;
        #1 check("route_a_d_ready", d_ready, 1);
        step();
        d_valid = 1'b0;
        check("route_a_data", a, 8'h3C);
        check("route_a_valid", a_valid, 1);
        check("route_a_b_valid", b_valid, 0);
        step();
        check("route_a_one_cycle", a_valid, 0);
        check("route_a_b_still0", b_valid, 0);

        // basic route to B
        d = 8'hA5; sreg = 1'b1; d_valid = 1'b1; b_ready = 1'b1;
        step();
        d_valid = 1'b0;
        check("route_b_data", b, 8'hA5);
        check("route_b_valid", b_valid, 1);
        check("route_b_a_valid", a_valid, 0);
        step();
        check("route_b_one_cycle", b_valid, 0);

        // stall on A, isolation of B
        a_ready = 1'b0; b_ready = 1'b0;
        d = 8'h11; sreg = 1'b0; d_valid = 1'b1;
        step();
        check("stall_a_loaded", a, 8'h11);
        d = 8'h22;
        #1 check("stall_d_ready_low", d_ready, 0);
        step();
        check("stall_a_held", a, 8'h11);
        check("stall_a_valid", a_valid, 1);
        sreg = 1'b1;
        #1 check("stall_switch_ready", d_ready, 1);
        step();
        d_valid = 1'b0;
        check("stall_b_data", b, 8'h22);
        check("stall_b_valid", b_valid, 1);
        check("stall_a_still", a, 8'h11);
        a_ready = 1'b1;
        step();
        check("stall_a_drained", a_valid, 0);
        check("stall_b_kept", b_valid, 1);
        check("stall_b_kept_data", b, 8'h22);
        b_ready = 1'b1;
        step();
        check("stall_b_drained", b_valid, 0);

        // full throughput, alternating ports
        a_ready = 1'b1; b_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d       = 8'(i);
            sreg    = i[0];
            d_valid = 1'b1;
            #1 check("thru_d_ready", d_ready, 1);
            step();
            if (i[0]) begin
                check("thru_b_data", b, 32'(i));
                check("thru_b_valid", b_valid, 1);
                check("thru_a_idle", a_valid, 0);
            end else begin
                check("thru_a_data", a, 32'(i));
                check("thru_a_valid", a_valid, 1);
                check("thru_b_idle", b_valid, 0);
            end
        end
        d_valid = 1'b0;
        step();

        // simultaneous drain and load on A
        a_ready = 1'b0;
        d = 8'h55; sreg = 1'b0; d_valid = 1'b1;
        step();
        check("sim_a_55", a, 8'h55);
        a_ready = 1'b1;
        d = 8'h66;
        #1 check("sim_d_ready", d_ready, 1);
        step();
        d_valid = 1'b0;
        check("sim_a_66", a, 8'h66);
        check("sim_a_valid", a_valid, 1);
        step();
        check("sim_a_empty", a_valid, 0);
        check("sim_55_once", cnt55, 1);

        // randomized traffic against a reference model
        m_a = a; m_b = b; m_av = a_valid; m_bv = b_valid;
        for (int i = 0; i < 10000; i++) begin
            d       = 8'($urandom_range(0, 255));
            d_valid = 1'($urandom_range(0, 1));
            sreg    = 1'($urandom_range(0, 1));
            a_ready = ($urandom_range(0, 3) != 0);
            b_ready = ($urandom_range(0, 3) != 0);
            #1;
            m_rdy  = sreg ? (!m_bv || b_ready) : (!m_av || a_ready);
            m_xfer = d_valid && m_rdy;
            check("rnd_d_ready", d_ready, m_rdy);
            @(posedge clk);
            if (m_xfer && !sreg) begin m_a = d; m_av = 1'b1; end
            else if (m_av && a_ready) m_av = 1'b0;
            if (m_xfer && sreg) begin m_b = d; m_bv = 1'b1; end
            else if (m_bv && b_ready) m_bv = 1'b0;
            #1;
            check("rnd_a_valid", a_valid, m_av);
            check("rnd_b_valid", b_valid, m_bv);
            if (m_av) check("rnd_a_data", a, m_a);
            if (m_bv) check("rnd_b_data", b, m_b);
        end

        // asynchronous reset mid-stream
        a_ready = 1'b0; b_ready = 1'b0; d_valid = 1'b1;
        d = 8'h77; sreg = 1'b0;
        step();
        d = 8'h88; sreg = 1'b1;
        step();
        d_valid = 1'b0;
        check("pre_async_a_valid", a_valid, 1);
        check("pre_async_b_valid", b_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("async_a_valid", a_valid, 0);
        check("async_b_valid", b_valid, 0);
        check("async_a", a, 0);
        check("async_b", b, 0);
        check("async_d_ready", d_ready, 1);
        step();
        reset = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_1_2.md
# demux_1_2

Registered 1-to-2 stream demultiplexer: the fan-out counterpart of the 2:1 select mux, steering one input data stream to one of two output ports under control of `sreg`. Each output port owns a one-entry holding register with valid/ready handshake, so a stalled destination never corrupts data or blocks traffic routed to the other port. Used wherever a single producer feeds two consumers, such as result write-back to one of two register banks.

## Interface
- `width`, 8, data width in bits of the input and both output ports.

- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset.
- `d`  input  width  input data.
- `d_valid`  input  1  input data valid.
- `d_ready`  output  1  block accepts `d` this cycle.
- `sreg`  input  1  route select, sampled with `d`: 0 routes to port A, 1 routes to port B.
- `a`  output  width  port A data, registered.
- `a_valid`  output  1  port A holds data.
- `a_ready`  input  1  port A consumer accepts.
- `b`  output  width  port B data, registered.
- `b_valid`  output  1  port B holds data.
- `b_ready`  input  1  port B consumer accepts.

## Operation
- Input transfer: `d_valid && d_ready` at a rising edge.
- Output transfer on port X: `X_valid && X_ready` at a rising edge.
- `d_ready` is combinational from `sreg`, the selected port's valid and the selected port's ready:
  - `sreg`=0: `d_ready = !a_valid || a_ready`
  - `sreg`=1: `d_ready = !b_valid || b_ready`
  - `d_ready` must not depend on `d_valid`.
- Selected port X, per edge:
  - Input transfer: X register loads `d` and `X_valid` is set to 1. This applies even if X is draining in the same cycle. Back-to-back throughput is 1 word per cycle.
  - Output transfer with no input transfer: `X_valid` clears to 0.
- Unselected port: behaves only under its own output handshake. It drains independently and is never loaded.
- While `X_valid && !X_ready`, `X` is held bit-stable.
- `sreg` and `d` are meaningful only while `d_valid`=1. Changing `sreg` while `d_valid`=1 and `d_ready`=0 is legal: `d_ready` re-evaluates against the new target.
- No reordering between ports is guaranteed. Ordering within one port is strict FIFO (depth 1).

## Timing
- Reset (asynchronous assert, synchronous deassert is the system's job):
  - `a`, `b` = 0
  - `a_valid`, `b_valid` = 0
  - `d_ready` = 1
- Reset asserted mid-operation discards any held word immediately. Outputs take their reset values without waiting for a clock.
- Latency: a word accepted at edge N appears on `X` with `X_valid`=1 after edge N.
- Boundary behaviour:
  - Full port (`X_valid`=1, `X_ready`=0) selected: `d_ready`=0 and the input stalls.
  - The other port keeps draining during that stall.
  - Full port with `X_ready`=1: pass-through at full rate with no bubble.
  - Empty port: accepts regardless of `X_ready`.
- No combinational path from `d` to `a`/`b`.

## Test plan
- Reset: hold `reset`=0 with random inputs -> `a_valid`=`b_valid`=0, `a`=`b`=0, `d_ready`=1. Assert `reset` low mid-stream -> valids drop with no clock edge.
- Basic route: `d`=8'h3C, `sreg`=0, `d_valid` for 1 cycle, `a_ready`=1 -> `a`=8'h3C and `a_valid`=1 for exactly one cycle. `b_valid` stays 0. Repeat with `sreg`=1 and 8'hA5 -> appears on `b` only.
- Stall and isolation: `a_ready`=0, send 8'h11 to A, then attempt 8'h22 to A -> `d_ready`=0 and `a` held at 8'h11. Switch `sreg`=1 with 8'h22 -> accepted, `b`=8'h22 next cycle. Raise `a_ready` -> 8'h11 drains.
- Full throughput: 16 consecutive words 0x00..0x0F alternating `sreg`, both readys = 1 -> `d_ready` constantly 1. Each port receives its 8 words in order, one cycle after acceptance.
- Simultaneous drain and load: A holds 8'h55, `a_ready`=1 and `d`=8'h66 to A in the same cycle -> `a_valid` stays 1 and `a`=8'h66 next cycle. 8'h55 is counted as consumed exactly once.
- Random: randomized `d_valid`/`sreg`/readys for 10k cycles against a scoreboard -> no loss, no duplication, per-port order preserved, data stable under stall.
